axis_frame_streamer: RTL and testbench

- AXI-Stream frame source that feeds the FFT/peak-detect chain of the acquisition path.
- Accepts continuous 32-bit IQ samples on a slave stream and assembles them into frames of 2^FFT_LENGTH_LOG2 words in a ping-pong buffer.
- Replays each full frame on a master stream with tlast on the final word and a per-word sample index aligned to the data (the index consumed downstream as i_index).

---
 rtl/axis_frame_streamer_if.sv | 9 +
 rtl/axis_frame_streamer.sv | 101 ++++++++++
 tb/tb_axis_frame_streamer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_streamer_if.sv
// axis_frame_streamer_if: AXI-Stream handshake bundle with producer (master) and consumer (slave) views.
interface axis_frame_streamer_if #(parameter int DW = 32);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave (input tvalid, tdata, output tready);
endinterface

// File: rtl/axis_frame_streamer.sv
// axis_frame_streamer: ping-pong buffer that collects 2^FFT_LENGTH_LOG2 samples and replays each frame with index/tlast.
// Optional AXIS_FRAME_DROP_EN: input never stalls; samples hitting a full bank are dropped and counted on o_drop_count.
module axis_frame_streamer #(
  parameter int DSIZE           = 32,
  parameter int DSIZE_DIV2      = 16,
  parameter int FFT_LENGTH_LOG2 = 12
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  axis_frame_streamer_if.slave  s00,
  axis_frame_streamer_if.master m00,
  output logic [DSIZE_DIV2-1:0] o_index,
  output logic                  o_busy
`ifdef AXIS_FRAME_DROP_EN
  ,
  output logic [DSIZE_DIV2-1:0] o_drop_count
`endif
);
  localparam int L = FFT_LENGTH_LOG2;
  localparam logic [L-1:0] LAST = '1;
  typedef enum logic {IDLE, READ} state_t;
  state_t state_q;
  logic [DSIZE-1:0] mem_q [2**(L+1)];
  logic [DSIZE-1:0] rdata_q, tdata_q;
  logic [L-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [DSIZE_DIV2-1:0] index_q;
  logic [1:0] full_q;
  logic wr_bank_q, rd_bank_q, rvalid_q, tvalid_q, tlast_q;
  logic wr_en, done_hs, ld, start, adv, rd_en;
  assign wr_en     = s00.tvalid && !full_q[wr_bank_q];
  assign done_hs   = state_q == READ && tvalid_q && m00.tready && tlast_q;
  assign ld        = state_q == READ && (!tvalid_q || m00.tready) && !done_hs;
  assign start     = state_q == IDLE && full_q[rd_bank_q];
  assign adv       = ld && rvalid_q && rd_ptr_q != LAST;
  assign rd_en     = start || adv;
  assign rd_ptr_nx = start ? '0 : rd_ptr_q + 1'b1;
  assign m00.tvalid = tvalid_q;
  assign m00.tdata  = tdata_q;
  assign m00.tlast  = tlast_q;
  assign o_index    = index_q;
  assign o_busy     = |full_q || state_q == READ;
  always_ff @(posedge s00_axis_aclk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_ptr_q}] <= s00.tdata;
    if (rd_en) rdata_q <= mem_q[{rd_bank_q, rd_ptr_nx}];
  end
  // rdata_q holds the word at rd_ptr_q while rvalid_q; it is prefetched one ahead of the output register
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q   <= IDLE;
      full_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rvalid_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      index_q   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (wr_ptr_q == LAST) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= !wr_bank_q;
        end
      end
      if (rd_en) rd_ptr_q <= rd_ptr_nx;
      if (start) begin
        state_q  <= READ;
        rvalid_q <= 1'b1;
      end
      if (done_hs) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= !rd_bank_q;
        state_q           <= IDLE;
        tvalid_q          <= 1'b0;
      end
      if (ld) begin
        tvalid_q <= rvalid_q;
        if (rvalid_q) begin
          tdata_q  <= rdata_q;
          index_q  <= DSIZE_DIV2'(rd_ptr_q);
          tlast_q  <= rd_ptr_q == LAST;
          rvalid_q <= rd_ptr_q != LAST;
        end
      end
    end
  end
`ifdef AXIS_FRAME_DROP_EN
  logic [DSIZE_DIV2-1:0] drop_q;
  assign s00.tready   = 1'b1;
  assign o_drop_count = drop_q;
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) drop_q <= '0;
    else if (s00.tvalid && full_q[wr_bank_q] && drop_q != '1) drop_q <= drop_q + 1'b1;
  end
`else
  assign s00.tready = !full_q[wr_bank_q];
`endif
endmodule

// File: tb/tb_axis_frame_streamer.sv
// tb_axis_frame_streamer: table-driven frame runs plus hand-written latency, gap, backpressure and reset sequences.
module tb_axis_frame_streamer;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  axis_frame_streamer_if #(.DW(32)) s_if ();
  axis_frame_streamer_if #(.DW(32)) m_if ();
  logic [15:0] o_index;
  logic        o_busy;
`ifdef AXIS_FRAME_DROP_EN
  logic [15:0] o_drop_count;
`endif
  axis_frame_streamer #(.DSIZE(32), .DSIZE_DIV2(16), .FFT_LENGTH_LOG2(3)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00(s_if), .m00(m_if),
    .o_index(o_index), .o_busy(o_busy)
`ifdef AXIS_FRAME_DROP_EN
    , .o_drop_count(o_drop_count)
`endif
  );
  typedef struct { int nsamp; logic [15:0] pat; int exp_words; } vec_t;
  vec_t vecs [5];
  logic [47:0] exp_q [$];
  logic [47:0] e;
  logic [48:0] held;
  logic sb_en = 1'b1, stalled = 1'b0;
  int n_chk = 0, n_pass = 0, n_out = 0, push_cnt = 0, seq = 0;
  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endfunction
  // Scoreboard: accepted input words become expected output words with their frame index.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_en && s_if.tvalid && s_if.tready) begin
        exp_q.push_back({s_if.tdata, 16'(push_cnt % N)});
        push_cnt++;
      end
      if (m_if.tvalid) begin
        if (stalled) check("stall_hold", 64'({m_if.tdata, o_index, m_if.tlast}), 64'(held));
        if (m_if.tready) begin
          check("word_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word", 64'({m_if.tdata, o_index, m_if.tlast}), 64'({e, e[15:0] == 16'(N - 1)}));
          end
          n_out++;
        end
      end
      stalled = m_if.tvalid && !m_if.tready;
      held = {m_if.tdata, o_index, m_if.tlast};
    end
  end
  task automatic send(input int n);
    int sent = 0;
    for (int g = 0; g < 4000 && sent < n; g++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata = {16'(seq + 1), 16'(seq + 1)};
      @(negedge clk);
      if (s_if.tready) begin
        sent++;
        seq++;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    check("send_count", 64'(sent), 64'(n));
  endtask
  task automatic wait_out(input int tgt);
    for (int c = 0; c < 3000 && n_out < tgt; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("out_count", 64'(n_out), 64'(tgt));
    check("drained", 64'(exp_q.size()), 64'(0));
    check("busy_idle", 64'(o_busy), 64'(0));
  endtask
  task automatic wait_tlast();
    int c = 0;
    @(negedge clk);
    while (!(m_if.tvalid && m_if.tready && m_if.tlast) && c < 2000) begin
      c++;
      @(negedge clk);
    end
    check("tlast_seen", 64'(m_if.tvalid && m_if.tready && m_if.tlast), 64'(1));
  endtask
  task automatic check_reset();
    check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_tlast", 64'(m_if.tlast), 64'(0));
    check("rst_tdata", 64'(m_if.tdata), 64'(0));
    check("rst_index", 64'(o_index), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_s_tready", 64'(s_if.tready), 64'(1));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int tgt, p0, c, lat, idle;
    vecs[0] = '{8, 16'hffff, 8};
    vecs[1] = '{16, 16'hffff, 16};
    vecs[2] = '{8, 16'h9999, 8};
    vecs[3] = '{16, 16'h5a5a, 16};
    vecs[4] = '{16, 16'h0001, 16};
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    m_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // first frame 0x00010001..0x00080008: word 0 valid two edges after the 8th write
    m_if.tready = 1'b1;
    tgt = n_out + 8;
    send(8);
    lat = 0;
    @(negedge clk);
    while (!m_if.tvalid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'(2));
    wait_out(tgt);
    for (int i = 0; i < 5; i++) begin
      tgt = n_out + vecs[i].exp_words;
      fork
        send(vecs[i].nsamp);
        for (int k = 0; k < 4000 && n_out < tgt; k++) begin
          m_if.tready = vecs[i].pat[k % 16];
          @(posedge clk); #1;
        end
      join
      m_if.tready = 1'b1;
      wait_out(tgt);
    end
    // back-to-back frames: two idle cycles between tlast and the next word 0
    tgt = n_out + 16;
    fork send(16); join_none
    wait_tlast();
    idle = 0;
    @(negedge clk);
    while (!m_if.tvalid && idle < 20) begin
      idle++;
      @(negedge clk);
    end
    check("frame_gap", 64'(idle), 64'(2));
    check("gap_word0_index", 64'(o_index), 64'(0));
    wait_out(tgt);
`ifndef AXIS_FRAME_DROP_EN
    m_if.tready = 1'b0;
    p0 = push_cnt;
    tgt = n_out + 24;
    fork send(24); join_none
    repeat (40) @(posedge clk);
    #1;
    check("bp_accepted", 64'(push_cnt - p0), 64'(16));
    check("bp_s_tready", 64'(s_if.tready), 64'(0));
    m_if.tready = 1'b1;
    wait_tlast();
    @(negedge clk);
    check("tready_back", 64'(s_if.tready), 64'(1));
    wait_out(tgt);
`endif
    // reset while word 4 is presented and the second bank is half filled
    m_if.tready = 1'b0;
    send(12);
    m_if.tready = 1'b1;
    c = 0;
    @(negedge clk);
    while (!(m_if.tvalid && o_index == 16'd4) && c < 200) begin
      c++;
      @(negedge clk);
    end
    check("reached_word4", 64'(o_index), 64'(4));
    #1;
    rst_n = 1'b0;
    m_if.tready = 1'b0;
    exp_q.delete();
    push_cnt = 0;
    stalled = 1'b0;
    #1;
    check_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    tgt = n_out + 8;
    send(8);
    wait_out(tgt);
`ifdef AXIS_FRAME_DROP_EN
    sb_en = 1'b0;
    m_if.tready = 1'b0;
    for (int i = 1; i <= 16; i++) exp_q.push_back({16'(seq + i), 16'(seq + i), 16'((i - 1) % N)});
    tgt = n_out + 16;
    send(20);
    check("drop_s_tready", 64'(s_if.tready), 64'(1));
    check("drop_count", 64'(o_drop_count), 64'(4));
    m_if.tready = 1'b1;
    wait_out(tgt);
    sb_en = 1'b1;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
